// File: rtl/aes_pkg.sv
// Shared definitions for the AES_Encrypt sequencing controller and its benches.
package aes_pkg;

    localparam int unsigned AES_BLK_W = 128;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} sched_state_e;

    // FIPS-197 known-answer vectors
    localparam logic [AES_BLK_W-1:0] KAT_A_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [AES_BLK_W-1:0] KAT_A_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [AES_BLK_W-1:0] KAT_A_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [AES_BLK_W-1:0] KAT_B_KEY = 128'h0;
    localparam logic [AES_BLK_W-1:0] KAT_B_PT  = 128'h0;
    localparam logic [AES_BLK_W-1:0] KAT_B_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

endpackage

// File: rtl/aes_lat_counter.sv
// Loadable down-counter that parks at zero; zero flag marks the capture cycle.
module aes_lat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/aes_encrypt_sched.sv
// Holds one job on the AES_Encrypt inputs for LATENCY cycles, captures the result and
// returns it through a valid/ready master port.
module aes_encrypt_sched
    import aes_pkg::*;
#(
    parameter int unsigned LATENCY = 12,
    parameter bit          ZEROIZE = 1'b1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [AES_BLK_W-1:0] s_plaintext,
    input  logic [AES_BLK_W-1:0] s_key,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [AES_BLK_W-1:0] m_ciphertext,
    output logic [AES_BLK_W-1:0] aes_in,
    output logic [AES_BLK_W-1:0] aes_key,
    input  logic [AES_BLK_W-1:0] aes_out,
    output logic                 busy,
    output logic                 trigger,
    output logic [CNT_W-1:0]     enc_count
);

    localparam logic [7:0] LOAD_VAL = 8'(LATENCY - 1);

    sched_state_e         state_q, state_d;
    logic [AES_BLK_W-1:0] in_q, in_d, key_q, key_d, ct_q, ct_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 accept, cnt_zero;

    assign accept = (state_q == ST_IDLE) && s_valid;

    aes_lat_counter #(
        .W (8)
    ) u_lat (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (LOAD_VAL),
        .dec_i      (state_q == ST_RUN),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        key_d   = key_q;
        ct_d    = ct_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d = ST_RUN;
                    in_d    = s_plaintext;
                    key_d   = s_key;
                end
            end
            ST_RUN: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                    ct_d    = aes_out;
                    count_d = count_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                    if (ZEROIZE) begin
                        in_d  = '0;
                        key_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            in_q    <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            count_q <= count_d;
        end
    end

    // Every output is a register or a pure state decode.
    assign s_ready      = (state_q == ST_IDLE);
    assign m_valid      = (state_q == ST_DONE);
    assign trigger      = (state_q == ST_RUN);
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign aes_in       = in_q;
    assign aes_key      = key_q;
    assign m_ciphertext = ct_q;
    assign enc_count    = count_q;

endmodule

// File: tb/tb_aes_encrypt_sched.sv
// Bench for aes_encrypt_sched: three instances (LAT 12 zeroize, LAT 12 keep, LAT 1 4-bit count).
module tb_aes_encrypt_sched;
    import aes_pkg::*;

    localparam int unsigned LAT_A = 12;
    localparam int unsigned LAT_B = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]   s_valid, s_ready, m_valid, m_ready, busy, trigger;
    logic [127:0] s_pt [3];
    logic [127:0] s_key [3];
    logic [127:0] m_ct [3];
    logic [127:0] aes_in [3];
    logic [127:0] aes_key [3];
    logic [127:0] aes_out [3];
    logic [31:0]  cnt0, cnt1;
    logic [3:0]   cnt2;

    int checks = 0;
    int failures = 0;
    int e0 = 0, e1 = 0, e2 = 0;

    aes_encrypt_sched #(.LATENCY(LAT_A), .ZEROIZE(1'b1), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_plaintext(s_pt[0]), .s_key(s_key[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .m_ciphertext(m_ct[0]), .aes_in(aes_in[0]), .aes_key(aes_key[0]), .aes_out(aes_out[0]),
        .busy(busy[0]), .trigger(trigger[0]), .enc_count(cnt0));

    aes_encrypt_sched #(.LATENCY(LAT_A), .ZEROIZE(1'b0), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_plaintext(s_pt[1]), .s_key(s_key[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .m_ciphertext(m_ct[1]), .aes_in(aes_in[1]), .aes_key(aes_key[1]), .aes_out(aes_out[1]),
        .busy(busy[1]), .trigger(trigger[1]), .enc_count(cnt1));

    aes_encrypt_sched #(.LATENCY(LAT_B), .ZEROIZE(1'b0), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .s_plaintext(s_pt[2]), .s_key(s_key[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
        .m_ciphertext(m_ct[2]), .aes_in(aes_in[2]), .aes_key(aes_key[2]), .aes_out(aes_out[2]),
        .busy(busy[2]), .trigger(trigger[2]), .enc_count(cnt2));

    // Stand-in for AES_Encrypt: exact on the known-answer vectors, a keyed mix otherwise.
    function automatic logic [127:0] core_f(input logic [127:0] pt, input logic [127:0] k);
        if (pt == KAT_A_PT && k == KAT_A_KEY) return KAT_A_CT;
        if (pt == KAT_B_PT && k == KAT_B_KEY) return KAT_B_CT;
        return {pt[63:0] ^ k[127:64], pt[127:64] ^ k[63:0]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
    endfunction

    // Core output settles exactly LAT cycles after its inputs change.
    for (genvar g = 0; g < 3; g++) begin : g_core
        localparam int L = (g == 2) ? LAT_B : LAT_A;
        if (L == 1) begin : g_comb
            assign aes_out[g] = core_f(aes_in[g], aes_key[g]);
        end else begin : g_pipe
            logic [127:0] pipe [L-1];
            always @(posedge clk) begin
                pipe[0] <= core_f(aes_in[g], aes_key[g]);
                for (int k = 1; k < L - 1; k++) pipe[k] <= pipe[k-1];
            end
            assign aes_out[g] = pipe[L-2];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake-accepted job must come back in order with the core's answer.
    for (genvar g = 0; g < 3; g++) begin : g_sb
        logic [127:0] q [$];
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
            end else begin
                if (s_valid[g] && s_ready[g]) q.push_back(core_f(s_pt[g], s_key[g]));
                if (m_valid[g] && m_ready[g]) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb%0d_unexpected actual=%h required=none", g, m_ct[g]);
                    end else begin
                        check($sformatf("sb%0d_order", g), m_ct[g], q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic do_job(input int i, input logic [127:0] pt, input logic [127:0] k,
                          input int rdly, output logic [127:0] ct, output int lat,
                          output int trig);
        int n;
        s_pt[i] = pt;
        s_key[i] = k;
        s_valid[i] = 1'b1;
        n = 0;
        while (!s_ready[i] && n < 50) begin
            tick();
            n++;
        end
        tick();
        s_valid[i] = 1'b0;
        lat = 0;
        trig = 0;
        while (!m_valid[i] && lat < 300) begin
            if (trigger[i]) trig++;
            tick();
            lat++;
        end
        repeat (rdly) tick();
        ct = m_ct[i];
        m_ready[i] = 1'b1;
        tick();
        m_ready[i] = 1'b0;
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    task automatic check_reset();
        check("rst_flags", 128'({s_ready, m_valid, busy, trigger}), 128'({3'b111, 9'b0}));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_in%0d", i), aes_in[i], '0);
            check($sformatf("rst_key%0d", i), aes_key[i], '0);
            check($sformatf("rst_ct%0d", i), m_ct[i], '0);
        end
        check("rst_cnt", 128'({cnt0, cnt1, cnt2}), '0);
    endtask

    initial begin
        vec_t         tbl [4];
        logic [127:0] ct;
        int           lat, trig, bad, mv_seen, idx;
        int           acc [$];
        logic [127:0] res [$];

        tbl[0] = '{KAT_A_PT, KAT_A_KEY, KAT_A_CT};
        tbl[1] = '{KAT_B_PT, KAT_B_KEY, KAT_B_CT};
        for (int i = 2; i < 4; i++) begin
            tbl[i].pt = rnd128();
            tbl[i].key = rnd128();
            tbl[i].ct = core_f(tbl[i].pt, tbl[i].key);
        end

        rst_n = 1'b0;
        s_valid = '0;
        m_ready = '0;
        for (int i = 0; i < 3; i++) begin
            s_pt[i] = '0;
            s_key[i] = '0;
        end
        tick();
        tick();
        check_reset();
        rst_n = 1'b1;

        // Table-driven jobs on the zeroizing LAT 12 instance
        for (int v = 0; v < 4; v++) begin
            do_job(0, tbl[v].pt, tbl[v].key, 0, ct, lat, trig);
            e0++;
            check($sformatf("tbl%0d_ct", v), ct, tbl[v].ct);
            check($sformatf("tbl%0d_lat", v), 128'(lat), 128'(LAT_A));
            check($sformatf("tbl%0d_trig", v), 128'(trig), 128'(LAT_A));
            check($sformatf("tbl%0d_cnt", v), 128'(cnt0), 128'(e0));
            check($sformatf("tbl%0d_zeroize", v), {aes_in[0] | aes_key[0]}, '0);
            check($sformatf("tbl%0d_idle", v), 128'(s_ready[0]), 128'(1));
        end

        // Held result with m_ready low; stray s_valid while busy must be ignored
        s_pt[0] = KAT_B_PT;
        s_key[0] = KAT_B_KEY;
        s_pt[1] = KAT_A_PT;
        s_key[1] = KAT_A_KEY;
        s_valid[1:0] = 2'b11;
        tick();
        s_valid[1:0] = 2'b00;
        repeat (LAT_A) tick();
        e0++;
        e1++;
        check("hold_mvalid", 128'(m_valid[1:0]), 128'(2'b11));
        check("hold_busy_trig", 128'({busy[1:0], trigger[1:0]}), 128'(4'b1100));
        s_pt[0] = rnd128();
        s_valid[0] = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (m_valid[1:0] !== 2'b11 || s_ready[1:0] !== 2'b00 || m_ct[0] !== KAT_B_CT ||
                m_ct[1] !== KAT_A_CT || cnt0 !== 32'(e0)) bad++;
        end
        check("hold_stable", 128'(bad), '0);
        s_valid[0] = 1'b0;
        m_ready[1:0] = 2'b11;
        tick();
        m_ready[1:0] = 2'b00;
        check("release_idle", 128'({s_ready[1:0], m_valid[1:0], busy[1:0]}), 128'(6'b110000));
        check("z1_in", aes_in[0] | aes_key[0], '0);
        check("z0_in", aes_in[1], KAT_A_PT);
        check("z0_key", aes_key[1], KAT_A_KEY);
        check("hold_cnt1", 128'(cnt1), 128'(e1));

        // Back-to-back with s_valid held and m_ready tied high
        idx = 0;
        s_pt[0] = KAT_A_PT;
        s_key[0] = KAT_A_KEY;
        s_valid[0] = 1'b1;
        m_ready[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (s_valid[0] && s_ready[0]) begin
                acc.push_back(c);
                idx++;
            end
            if (m_valid[0]) res.push_back(m_ct[0]);
            tick();
            if (idx == 1) begin
                s_pt[0] = KAT_B_PT;
                s_key[0] = KAT_B_KEY;
            end else if (idx >= 2) begin
                s_valid[0] = 1'b0;
            end
        end
        m_ready[0] = 1'b0;
        e0 += 2;
        check("b2b_accepts", 128'(acc.size()), 128'(2));
        check("b2b_results", 128'(res.size()), 128'(2));
        if (acc.size() == 2) check("b2b_spacing", 128'(acc[1] - acc[0]), 128'(LAT_A + 2));
        if (res.size() == 2) begin
            check("b2b_first", res[0], KAT_A_CT);
            check("b2b_second", res[1], KAT_B_CT);
        end
        check("b2b_cnt", 128'(cnt0), 128'(e0));

        // Reset at cycle 5 of RUN aborts the job
        s_pt[0] = KAT_A_PT;
        s_key[0] = KAT_A_KEY;
        s_valid[0] = 1'b1;
        tick();
        s_valid[0] = 1'b0;
        mv_seen = 0;
        repeat (4) begin
            if (m_valid[0]) mv_seen++;
            tick();
        end
        check("mid_run_trig", 128'(trigger[0]), 128'(1));
        rst_n = 1'b0;
        tick();
        check_reset();
        rst_n = 1'b1;
        e0 = 0;
        e1 = 0;
        e2 = 0;
        repeat (LAT_A + 4) begin
            if (m_valid[0]) mv_seen++;
            tick();
        end
        check("abort_no_mvalid", 128'(mv_seen), '0);
        do_job(0, KAT_B_PT, KAT_B_KEY, 1, ct, lat, trig);
        e0++;
        check("after_rst_ct", ct, KAT_B_CT);
        check("after_rst_lat", 128'(lat), 128'(LAT_A));
        check("after_rst_cnt", 128'(cnt0), 128'(e0));

        // 4-bit counter wrap on the LATENCY 1 instance
        for (int j = 0; j < 17; j++) begin
            logic [127:0] pt, k;
            pt = (j == 0) ? KAT_A_PT : rnd128();
            k = (j == 0) ? KAT_A_KEY : rnd128();
            do_job(2, pt, k, $urandom_range(0, 2), ct, lat, trig);
            e2++;
            check($sformatf("l1_ct%0d", j), ct, core_f(pt, k));
            check($sformatf("l1_lat%0d", j), 128'(lat), 128'(LAT_B));
        end
        check("wrap_cnt", 128'(cnt2), 128'(e2 % 16));

        // Randomized jobs with random consumer stalls
        for (int j = 0; j < 12; j++) begin
            logic [127:0] pt, k;
            pt = rnd128();
            k = rnd128();
            do_job(0, pt, k, $urandom_range(0, 3), ct, lat, trig);
            e0++;
            check($sformatf("rnd_ct%0d", j), ct, core_f(pt, k));
            check($sformatf("rnd_lat%0d", j), 128'(lat), 128'(LAT_A));
            check($sformatf("rnd_cnt%0d", j), 128'(cnt0), 128'(e0));
        end
        for (int j = 0; j < 3; j++) begin
            logic [127:0] pt, k;
            pt = rnd128();
            k = rnd128();
            do_job(1, pt, k, $urandom_range(0, 3), ct, lat, trig);
            e1++;
            check($sformatf("keep_ct%0d", j), ct, core_f(pt, k));
            check($sformatf("keep_in%0d", j), aes_in[1], pt);
            check($sformatf("keep_key%0d", j), aes_key[1], k);
        end
        check("keep_cnt", 128'(cnt1), 128'(e1));

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
